mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Sits directly downstream of the pipeline datapath's MEM stage.
- Consumes its mem_ren/mem_wen/mem_addr/mem_dout and returns mem_din.
- Converts each MEM-stage access into a req/ack transaction on a multi-cycle data bus.
- Asserts mem_stall so the pipeline controller holds all stages until the access completes; also flags misaligned word accesses.

Parameters:
- TIMEOUT_CYCLES, 256: bus wait limit in cycles; used only when MEM_TIMEOUT_EN is defined.
- TO_CNT_W, 9: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  main clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_ren  in  1  read request from the MEM stage.
- mem_wen  in  1  write request from the MEM stage.
- mem_addr  in  32  byte address; word access only.
- mem_dout  in  32  store data from the MEM stage.
- mem_din  out  32  load data to the datapath; registered, held between accesses.
- mem_stall  out  1  combinational; high = pipeline must hold the MEM stage and everything upstream.
- mem_err  out  1  high for exactly the DONE cycle of an errored access.
- bus_req  out  1  registered; bus request.
- bus_we  out  1  registered; 1 = write.
- bus_addr  out  32  registered word address with [1:0] forced to 0.
- bus_wdata  out  32  registered write data.
- bus_rdata  in  32  read data, valid when bus_ack is high.
- bus_ack  in  1  one-cycle completion strobe.

Behaviour:
- Reset: state=IDLE; mem_din, bus_req, bus_we, bus_addr, bus_wdata, mem_err all 0; timeout counter 0.
- Reset mid-access: bus_req drops at the next edge; any later bus_ack is ignored.
- access = mem_ren | mem_wen. If both are high, the access is a write (wen has priority).
- FSM states: IDLE, BUSY, DONE.
- IDLE, access=0: mem_stall=0; stay in IDLE; bus_ack is ignored.
- IDLE, access=1, mem_addr[1:0]!=0:
  - mem_stall=1; no bus transaction.
  - Next state DONE with error latched; mem_din unchanged.
- IDLE, access=1, aligned:
  - mem_stall=1.
  - At the edge, load bus_addr={mem_addr[31:2],2'b00}, bus_we=mem_wen, bus_wdata=mem_dout; set bus_req=1; go to BUSY.
- BUSY:
  - mem_stall=1; bus_req, bus_addr, bus_we and bus_wdata stay stable.
  - On bus_ack=1: clear bus_req; if the access is a read, mem_din<=bus_rdata; go to DONE. An ack in the first BUSY cycle is legal.
- DONE:
  - mem_stall=0, so the pipeline advances at this edge.
  - mem_err = latched error flag; mem_din is valid for WB capture.
  - Next state IDLE unconditionally, so the same access is never reissued.
- Minimum MEM-stage residency for an aligned access is 3 cycles (IDLE, BUSY, DONE). Each extra cycle without ack adds one.
- Back-to-back accesses: the new access is seen in the IDLE cycle after DONE; no bubble beyond that.
- Writes never modify mem_din. mem_din holds its last load value indefinitely.
- An ack while not in BUSY is ignored.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop bus_req, go to DONE with mem_err=1, mem_din unchanged.
  - A late ack afterwards is ignored.
- Undefined: no counter logic; BUSY waits for bus_ack indefinitely, and mem_err arises only from misalignment.

Test Plan:
- Aligned read: mem_ren=1, mem_addr=0x0000_0010; ack after 2 BUSY cycles with bus_rdata=0x1234_5678 -> bus_addr=0x10, bus_we=0; mem_stall high 3 cycles; DONE cycle has mem_din=0x1234_5678, mem_stall=0, mem_err=0.
- Aligned write: mem_wen=1, addr 0x20, mem_dout=0xCAFE_0001; ack in first BUSY cycle -> bus_we=1, bus_wdata=0xCAFE_0001; exactly one bus_req pulse; mem_din keeps its prior value.
- Misaligned: mem_ren=1, addr 0x0000_0013 -> bus_req never rises; 1 stall cycle, then DONE with mem_err=1 for exactly 1 cycle.
- Back-to-back: read 0x40 then write 0x44 in consecutive instructions -> two separate bus transactions; no duplicate request; IDLE->BUSY->DONE sequence repeats.
- Reset during BUSY: assert rst with bus_req=1, then ack the next cycle -> bus_req=0 after the edge; state IDLE; all outputs 0; ack has no effect.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack -> bus_req drops after 4 BUSY cycles; mem_err=1 in DONE; mem_stall releases.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage bridge: turns pipeline load/store requests into req/ack bus transactions.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned TO_CNT_W       = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

    if ((TO_CNT_W < 32'd1) || (TO_CNT_W > 32'd31) || (TIMEOUT_CYCLES < 32'd1) ||
        (TIMEOUT_CYCLES >= (32'd1 << TO_CNT_W))) begin : g_cfg_check
        $error("mem_access_unit: TO_CNT_W cannot hold TIMEOUT_CYCLES");
    end

    state_t      state_r;
    state_t      state_s;
    logic        access_s;
    logic        mem_stall_s;
    logic [31:0] mem_din_r;
    logic [31:0] mem_din_s;
    logic        mem_err_r;
    logic        mem_err_s;
    logic        bus_req_r;
    logic        bus_req_s;
    logic        bus_we_r;
    logic        bus_we_s;
    logic [31:0] bus_addr_r;
    logic [31:0] bus_addr_s;
    logic [31:0] bus_wdata_r;
    logic [31:0] bus_wdata_s;
`ifdef MEM_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt_r;
    logic [TO_CNT_W-1:0] to_cnt_s;
`endif

    assign access_s = mem_ren | mem_wen;

    // Next-state, stall and next register values for the access sequencer.
    always_comb begin
        state_s     = state_r;
        mem_stall_s = 1'b0;
        mem_din_s   = mem_din_r;
        mem_err_s   = 1'b0;
        bus_req_s   = bus_req_r;
        bus_we_s    = bus_we_r;
        bus_addr_s  = bus_addr_r;
        bus_wdata_s = bus_wdata_r;
`ifdef MEM_TIMEOUT_EN
        to_cnt_s    = to_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (access_s) begin
                    mem_stall_s = 1'b1;
                    if (is_misaligned(mem_addr[1:0])) begin
                        // Error path skips the bus entirely; mem_err marks the DONE cycle.
                        state_s   = DONE;
                        mem_err_s = 1'b1;
                    end else begin
                        state_s     = BUSY;
                        bus_req_s   = 1'b1;
                        bus_we_s    = mem_wen;
                        bus_addr_s  = {mem_addr[31:2], 2'b00};
                        bus_wdata_s = mem_dout;
`ifdef MEM_TIMEOUT_EN
                        to_cnt_s    = {TO_CNT_W{1'b0}};
`endif
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                mem_stall_s = 1'b1;
                if (bus_ack) begin
                    bus_req_s = 1'b0;
                    state_s   = DONE;
                    if (!bus_we_r) begin
                        mem_din_s = bus_rdata;
                    end else begin
                        mem_din_s = mem_din_r;
                    end
                end else begin
`ifdef MEM_TIMEOUT_EN
                    if (to_cnt_r == TO_CNT_W'(TIMEOUT_CYCLES - 32'd1)) begin
                        bus_req_s = 1'b0;
                        mem_err_s = 1'b1;
                        state_s   = DONE;
                    end else begin
                        to_cnt_s = to_cnt_r + {{(TO_CNT_W-1){1'b0}}, 1'b1};
                    end
`else
                    state_s = BUSY;
`endif
                end
            end
            DONE: begin
                // Always return to IDLE so a held MEM-stage request is never reissued.
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and bus output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_din_r   <= 32'h0000_0000;
            mem_err_r   <= 1'b0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'h0000_0000;
            bus_wdata_r <= 32'h0000_0000;
`ifdef MEM_TIMEOUT_EN
            to_cnt_r    <= {TO_CNT_W{1'b0}};
`endif
        end else begin
            mem_din_r   <= mem_din_s;
            mem_err_r   <= mem_err_s;
            bus_req_r   <= bus_req_s;
            bus_we_r    <= bus_we_s;
            bus_addr_r  <= bus_addr_s;
            bus_wdata_r <= bus_wdata_s;
`ifdef MEM_TIMEOUT_EN
            to_cnt_r    <= to_cnt_s;
`endif
        end
    end

    assign mem_din   = mem_din_r;
    assign mem_stall = mem_stall_s;
    assign mem_err   = mem_err_r;
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;

endmodule
